// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM pipeline register with handshake, optional skid entry, flush and stall counter
module ex_mem_pipe_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [CNT_W-1:0]  StallCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_v;
  logic [DATA_W-1:0] m_d;
  logic [CTRL_W-1:0] m_c;
  logic              in_fire;
  logic              out_fire;
  logic [CNT_W-1:0]  stall_q;

  assign in_fire    = InValid & InReady;
  assign out_fire   = m_v & OutReady;
  assign OutValid   = m_v;
  assign OutData    = m_d;
  assign OutCtrl    = m_v ? m_c : '0;
  assign StallCount = stall_q;

  generate
    if (SKID != 0) begin : g_skid
      logic              s_v;
      logic [DATA_W-1:0] s_d;
      logic [CTRL_W-1:0] s_c;
      logic              rdy_q;

      // Ready is a flop so OutReady never reaches InReady combinationally.
      assign InReady = rdy_q;

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          m_v   <= 1'b0;
          m_d   <= '0;
          m_c   <= '0;
          s_v   <= 1'b0;
          s_d   <= '0;
          s_c   <= '0;
          rdy_q <= 1'b0;
        end else if (Flush) begin
          m_v   <= 1'b0;
          s_v   <= 1'b0;
          rdy_q <= 1'b1;
        end else if (out_fire && s_v) begin
          m_v   <= 1'b1;
          m_d   <= s_d;
          m_c   <= s_c;
          s_v   <= 1'b0;
          rdy_q <= 1'b1;
        end else if (in_fire && (!m_v || out_fire)) begin
          m_v   <= 1'b1;
          m_d   <= InData;
          m_c   <= InCtrl;
          rdy_q <= 1'b1;
        end else if (in_fire) begin
          s_v   <= 1'b1;
          s_d   <= InData;
          s_c   <= InCtrl;
          rdy_q <= 1'b0;
        end else begin
          if (out_fire) begin
            m_v <= 1'b0;
          end
          rdy_q <= !s_v;
        end
      end
    end else begin : g_single
      assign InReady = !Rst && (!m_v || OutReady);

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          m_v <= 1'b0;
          m_d <= '0;
          m_c <= '0;
        end else if (Flush) begin
          m_v <= 1'b0;
        end else if (in_fire) begin
          m_v <= 1'b1;
          m_d <= InData;
          m_c <= InCtrl;
        end else if (out_fire) begin
          m_v <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_q <= '0;
    end else if (m_v && !OutReady && !Flush && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - checks a skid instance (4-bit counter) and a single-entry instance against a queue model
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic [159:0] d;
    logic [15:0]  c;
  } ent_t;

  logic         clk, rst, in_valid, flush, out_ready;
  logic [159:0] in_data;
  logic [15:0]  in_ctrl;

  logic         s_in_ready, s_out_valid;
  logic [159:0] s_out_data;
  logic [15:0]  s_out_ctrl;
  logic [3:0]   s_stall;
  logic         n_in_ready, n_out_valid;
  logic [159:0] n_out_data;
  logic [15:0]  n_out_ctrl;
  logic [15:0]  n_stall;

  int checks = 0;
  int passes = 0;

  ent_t         qs[$];
  ent_t         qn[$];
  logic [159:0] hold_s, hold_n;
  logic [3:0]   cnt_s;
  logic [15:0]  cnt_n;
  bit           s_boot;

  ex_mem_pipe_reg #(.DATA_W(160), .CTRL_W(16), .SKID(1), .CNT_W(4)) dut_s (
    .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(s_in_ready), .InData(in_data),
    .InCtrl(in_ctrl), .Flush(flush), .OutValid(s_out_valid), .OutReady(out_ready),
    .OutData(s_out_data), .OutCtrl(s_out_ctrl), .StallCount(s_stall)
  );

  ex_mem_pipe_reg #(.DATA_W(160), .CTRL_W(16), .SKID(0), .CNT_W(16)) dut_n (
    .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(n_in_ready), .InData(in_data),
    .InCtrl(in_ctrl), .Flush(flush), .OutValid(n_out_valid), .OutReady(out_ready),
    .OutData(n_out_data), .OutCtrl(n_out_ctrl), .StallCount(n_stall)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    qs.delete();
    qn.delete();
    hold_s = '0;
    hold_n = '0;
    cnt_s  = '0;
    cnt_n  = '0;
    s_boot = 1'b1;
  endtask

  // Both instances are a FIFO of capacity 2 (skid) or 1 (single); flush empties it.
  task automatic model_edge();
    bit   rdy_s, rdy_n;
    ent_t e;
    if (rst) return;
    rdy_s = !s_boot && (qs.size() < 2);
    rdy_n = (qn.size() == 0) || out_ready;
    e.d = in_data;
    e.c = in_ctrl;
    if (flush) begin
      qs.delete();
      qn.delete();
    end else begin
      if (qs.size() > 0 && !out_ready && cnt_s != 4'hF) cnt_s = cnt_s + 4'd1;
      if (qn.size() > 0 && !out_ready && cnt_n != 16'hFFFF) cnt_n = cnt_n + 16'd1;
      if (qs.size() > 0 && out_ready) void'(qs.pop_front());
      if (qn.size() > 0 && out_ready) void'(qn.pop_front());
      if (in_valid && rdy_s) qs.push_back(e);
      if (in_valid && rdy_n) qn.push_back(e);
    end
    if (qs.size() > 0) hold_s = qs[0].d;
    if (qn.size() > 0) hold_n = qn[0].d;
    s_boot = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (s_out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", s_out_valid); else passes++;
    checks++; if (s_out_data !== 160'd0) $display("FAIL rst_data got=%h exp=0", s_out_data); else passes++;
    checks++; if (s_out_ctrl !== 16'd0) $display("FAIL rst_ctrl got=%h exp=0", s_out_ctrl); else passes++;
    checks++; if (s_stall !== 4'd0) $display("FAIL rst_stall got=%0d exp=0", s_stall); else passes++;
    checks++; if (s_in_ready !== 1'b0 || n_in_ready !== 1'b0) $display("FAIL rst_ready got=%b%b exp=00", s_in_ready, n_in_ready); else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b0) $display("FAIL rel_ready_pre got=%b exp=0", s_in_ready); else passes++;
    @(negedge clk);
    tick();
    #1;
    checks++; if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1) $display("FAIL rel_ready_post got=%b%b exp=11", s_in_ready, n_in_ready); else passes++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 160'(i);
      in_ctrl = 16'(i);
      tick();
      #1;
      checks++; if (s_out_valid !== 1'b1 || s_out_data !== 160'(i)) $display("FAIL stream_s_%0d got=%b/%0h exp=1/%0d", i, s_out_valid, s_out_data, i); else passes++;
      checks++; if (n_out_data !== 160'(i) || n_out_ctrl !== 16'(i)) $display("FAIL stream_n_%0d got=%0h/%0h exp=%0d", i, n_out_data, n_out_ctrl, i); else passes++;
    end
    in_valid = 1'b0;
    tick();
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_stall !== 4'd0 || n_stall !== 16'd0) $display("FAIL stream_end got=%b/%0d/%0d exp=0/0/0", s_out_valid, s_stall, n_stall); else passes++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 160'hA;
    in_ctrl   = 16'h1;
    tick();
    in_data = 160'hB;
    in_ctrl = 16'h2;
    #1;
    checks++; if (s_out_data !== 160'hA || s_in_ready !== 1'b1) $display("FAIL bp_first got=%0h/%b exp=a/1", s_out_data, s_in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (s_in_ready !== 1'b0 || s_out_data !== 160'hA || s_stall !== 4'd1) $display("FAIL bp_full got=%b/%0h/%0d exp=0/a/1", s_in_ready, s_out_data, s_stall); else passes++;
    tick();
    #1;
    checks++; if (s_stall !== 4'd2 || s_out_ctrl !== 16'h1) $display("FAIL bp_count got=%0d/%0h exp=2/1", s_stall, s_out_ctrl); else passes++;
    out_ready = 1'b1;
    #1;
    checks++; if (s_out_data !== 160'hA) $display("FAIL bp_order_a got=%0h exp=a", s_out_data); else passes++;
    tick();
    #1;
    checks++; if (s_out_valid !== 1'b1 || s_out_data !== 160'hB || s_in_ready !== 1'b1 || s_stall !== 4'd2) $display("FAIL bp_order_b got=%b/%0h/%b/%0d exp=1/b/1/2", s_out_valid, s_out_data, s_in_ready, s_stall); else passes++;
    tick();
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_out_data !== 160'hB) $display("FAIL bp_drain got=%b/%0h exp=0/b", s_out_valid, s_out_data); else passes++;
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = 16'hFFFF;
    in_data   = {5{$urandom}};
    tick();
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_out_ctrl !== 16'h0 || n_out_ctrl !== 16'h0) $display("FAIL bubble got=%b/%0h/%0h exp=0/0/0", s_out_valid, s_out_ctrl, n_out_ctrl); else passes++;
    checks++; if (s_stall !== 4'd2) $display("FAIL bubble_stall got=%0d exp=2", s_stall); else passes++;
  endtask

  task automatic test_flush();
    logic [3:0] st;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 160'hA;
    in_ctrl   = 16'h5;
    tick();
    in_data = 160'hB;
    tick();
    #1;
    checks++; if (s_in_ready !== 1'b0) $display("FAIL flush_pre_full got=%b exp=0", s_in_ready); else passes++;
    flush   = 1'b1;
    in_data = 160'hC;
    st = s_stall;
    tick();
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_out_ctrl !== 16'h0) $display("FAIL flush_kill got=%b/%b/%0h exp=0/1/0", s_out_valid, s_in_ready, s_out_ctrl); else passes++;
    checks++; if (s_stall !== st || s_out_data !== 160'hA) $display("FAIL flush_keep got=%0d/%0h exp=%0d/a", s_stall, s_out_data, st); else passes++;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++; if (s_out_valid !== 1'b0 || n_out_valid !== 1'b0) $display("FAIL flush_no_c_%0d got=%b%b exp=00", i, s_out_valid, n_out_valid); else passes++;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 160'hD;
    in_ctrl   = 16'h00F0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (s_out_valid !== 1'b1 || s_out_ctrl !== 16'h00F0 || s_stall !== 4'd5) $display("FAIL arst_pre got=%b/%0h/%0d exp=1/f0/5", s_out_valid, s_out_ctrl, s_stall); else passes++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_out_ctrl !== 16'h0 || s_stall !== 4'd0) $display("FAIL arst_s got=%b/%0h/%0d exp=0/0/0", s_out_valid, s_out_ctrl, s_stall); else passes++;
    checks++; if (n_out_valid !== 1'b0 || n_out_ctrl !== 16'h0 || n_stall !== 16'd0) $display("FAIL arst_n got=%b/%0h/%0d exp=0/0/0", n_out_valid, n_out_ctrl, n_stall); else passes++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 160'hE;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    #1;
    checks++; if (s_stall !== 4'd15) $display("FAIL sat_reach got=%0d exp=15", s_stall); else passes++;
    repeat (5) tick();
    #1;
    checks++; if (s_stall !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", s_stall); else passes++;
    checks++; if (n_stall !== 16'd20) $display("FAIL sat_wide got=%0d exp=20", n_stall); else passes++;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] exp_cs, exp_cn;
    int          errs;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 20) == 0;
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_ctrl   = 16'($urandom);
      #1;
      exp_cs = (qs.size() > 0) ? qs[0].c : 16'h0;
      exp_cn = (qn.size() > 0) ? qn[0].c : 16'h0;
      errs = 0;
      checks++; if (s_out_valid !== (qs.size() > 0) || s_in_ready !== (!s_boot && qs.size() < 2)) begin errs++; $display("FAIL rand_s_hs cyc=%0d got=%b/%b exp=%0d entries", k, s_out_valid, s_in_ready, qs.size()); end else passes++;
      checks++; if (s_out_data !== hold_s || s_out_ctrl !== exp_cs) begin errs++; $display("FAIL rand_s_out cyc=%0d got=%h/%h exp=%h/%h", k, s_out_data, s_out_ctrl, hold_s, exp_cs); end else passes++;
      checks++; if (s_stall !== cnt_s) begin errs++; $display("FAIL rand_s_stall cyc=%0d got=%0d exp=%0d", k, s_stall, cnt_s); end else passes++;
      checks++; if (n_out_valid !== (qn.size() > 0) || n_in_ready !== ((qn.size() == 0) || out_ready)) begin errs++; $display("FAIL rand_n_hs cyc=%0d got=%b/%b exp=%0d entries", k, n_out_valid, n_in_ready, qn.size()); end else passes++;
      checks++; if (n_out_data !== hold_n || n_out_ctrl !== exp_cn) begin errs++; $display("FAIL rand_n_out cyc=%0d got=%h/%h exp=%h/%h", k, n_out_data, n_out_ctrl, hold_n, exp_cn); end else passes++;
      checks++; if (n_stall !== cnt_n) begin errs++; $display("FAIL rand_n_stall cyc=%0d got=%0d exp=%0d", k, n_stall, cnt_n); end else passes++;
      if (errs > 0) break;
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised successor to the fixed EX/MEM latch: one pipeline-stage register between EX and MEM with a valid/ready handshake, an optional skid entry, synchronous flush and a stall-cycle counter.
- Carries an opaque data payload (ALU result, 64-bit result, store data, PC+4) and a control bundle (MemRead, MemWrite, RegWrite, ...).
- Invalid slots present as no-op bubbles: control outputs are zero.

Parameters:
- DATA_W, 160, payload width in bits.
- CTRL_W, 16, control-bundle width; forced to zero on bubbles.
- SKID, 1, 1 = two-entry skid buffer with a registered InReady; 0 = single entry with a combinational InReady.
- CNT_W, 16, stall-counter width.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- InValid  in  1  EX stage presents an instruction
- InReady  out  1  stage can accept
- InData  in  DATA_W  payload from EX
- InCtrl  in  CTRL_W  control bundle from EX
- Flush  in  1  synchronous kill of all held entries
- OutValid  out  1  MEM-side entry valid
- OutReady  in  1  MEM stage accepts
- OutData  out  DATA_W  held payload
- OutCtrl  out  CTRL_W  held control; zero when OutValid=0
- StallCount  out  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Reset (async, Rst=1): main entry M and skid entry S invalid; data/ctrl storage 0; StallCount=0.
  - Outputs during reset: OutValid=0, OutData=0, OutCtrl=0.
  - InReady during reset: 0, then 1 on the first cycle after release.
- Fire definitions: in_fire = InValid & InReady; out_fire = OutValid & OutReady.
- Outputs are driven from M only: OutValid=M.v, OutData=M.d, OutCtrl = M.v ? M.c : 0.
- Latency: one cycle from in_fire to OutValid when M is empty or draining.
- SKID=1:
  - InReady = !S.v, registered (no combinational path from OutReady).
  - out_fire & S.v: M <= S; S invalid. No input is accepted that cycle, since InReady=0.
  - in_fire & (!M.v | out_fire): M <= input.
  - in_fire & M.v & !out_fire: S <= input. InReady drops the next cycle.
  - out_fire with no in_fire and no S: M becomes invalid.
- SKID=0:
  - InReady = !M.v | OutReady (combinational).
  - in_fire loads M. out_fire without in_fire invalidates M.
- Ordering: strict FIFO; S is never overtaken by new input.
- Flush (sync, highest priority after reset):
  - Next edge: M.v=0, S.v=0; any in_fire that cycle is discarded.
  - Data registers keep their old contents; ctrl is masked by valid.
  - out_fire in the flush cycle still counts as consumed.
- Invalid entries never change OutData. Hold when OutValid & !OutReady: OutData and OutCtrl stable.
- StallCount: +1 each cycle OutValid & !OutReady & !Flush; saturates at 2^CNT_W-1; cleared only by Rst.
- Reset mid-operation: all entries dropped immediately, no partial transfer.
- Simultaneous in_fire, out_fire and S.v cannot occur because InReady=0 while S.v=1.

Test Plan:
- Reset then stream: Rst pulse, then InValid=1, InData=1,2,3 on consecutive cycles, OutReady=1 -> OutData 1,2,3 one cycle later each; StallCount=0.
- Back-pressure with skid (SKID=1): send A=0xA, B=0xB with OutReady=0 -> OutData=0xA held, InReady=0 after B, StallCount increments each cycle; raise OutReady -> 0xA then 0xB in order, InReady returns 1.
- Bubble masking: InValid=0 with InCtrl=16'hFFFF -> OutValid=0, OutCtrl=0.
- Flush with full skid: M=0xA, S=0xB, Flush=1 with InValid=1, InData=0xC -> next cycle OutValid=0, InReady=1, 0xC never appears.
- Async reset mid-stall: Rst asserted between edges while OutValid=1 -> OutValid, OutCtrl and StallCount go to 0 immediately, without waiting for Clk.
- Saturation: CNT_W=4, OutReady=0 for 20 cycles -> StallCount stops at 15.
